// File: rtl/ps2_map_pkg.sv
// Shared types and helpers for the PS/2 keymap: entry layout, ps2_key bit
// positions and the single-entry match rule.
package ps2_map_pkg;

    localparam int TOGGLE_BIT = 10;
    localparam int PRESS_BIT  = 9;
    localparam int EXT_BIT    = 8;

    typedef struct packed {
        logic       valid;
        logic       ignore_ext;
        logic       ext;
        logic [7:0] code;
    } map_entry_t;

    // A wildcard entry accepts the scancode with or without the E0 prefix.
    function automatic logic entry_match(input map_entry_t entry, input logic [8:0] key);
        return entry.valid && (entry.code == key[7:0]) &&
               (entry.ignore_ext || (entry.ext == key[8]));
    endfunction

endpackage

// File: rtl/ps2_autofire_gen.sv
// Free-running autofire timebase: counts 0..AF_PERIOD-1 and flips phase on
// each wrap, so phase is a square wave with AF_PERIOD-cycle half-periods.
module ps2_autofire_gen #(
    parameter int AF_PERIOD = 1500000
) (
    input  logic clk_sys,
    input  logic reset_n,
    output logic phase
);

    localparam int CW = (AF_PERIOD > 2) ? $clog2(AF_PERIOD) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            phase <= 1'b0;
        end else if (count == CW'(AF_PERIOD - 1)) begin
            count <= '0;
            phase <= ~phase;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_key_mapper.sv
// Runtime-programmable PS/2 scancode to button mapper, ORed with joystick bits.
// Define PS2_AUTOFIRE_EN to gate held keys with a per-button autofire square wave.
module ps2_key_mapper
    import ps2_map_pkg::*;
#(
    parameter int  NUM_BTN   = 16,
    parameter int  AF_PERIOD = 1500000,
    localparam int IW        = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [10:0]        ps2_key,
    input  logic               map_wr,
    input  logic [IW-1:0]      map_idx,
    input  logic [10:0]        map_entry,
    input  logic               clear_all,
    input  logic [NUM_BTN-1:0] joy_in,
    input  logic [NUM_BTN-1:0] af_mask,
    output logic [NUM_BTN-1:0] btn_out,
    output logic               key_event
);

    map_entry_t         keymap [NUM_BTN];
    logic [NUM_BTN-1:0] key_held;
    logic [NUM_BTN-1:0] match_vec;
    logic [NUM_BTN-1:0] held_eff;
    logic               primed;
    logic               old_toggle;
    logic               event_seen;

    // The first edge after reset only records the toggle level, so a stale level never reads as a keypress.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            primed     <= 1'b0;
            old_toggle <= 1'b0;
        end else begin
            primed     <= 1'b1;
            old_toggle <= ps2_key[TOGGLE_BIT];
        end
    end

    assign event_seen = primed && (ps2_key[TOGGLE_BIT] != old_toggle);

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            match_vec[i] = entry_match(keymap[i], ps2_key[EXT_BIT:0]);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            key_held  <= '0;
            key_event <= 1'b0;
        end else if (clear_all) begin
            key_held  <= '0;
            key_event <= 1'b0;
        end else begin
            key_event <= event_seen && (|match_vec);
            if (event_seen) begin
                for (int i = 0; i < NUM_BTN; i++) begin
                    if (match_vec[i]) begin
                        key_held[i] <= ps2_key[PRESS_BIT];
                    end
                end
            end
        end
    end

    // Writes land on the same edge as any lookup, so a coincident event still sees the old entry.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                keymap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (map_wr && (map_idx == IW'(i))) begin
                    keymap[i] <= map_entry_t'(map_entry);
                end
            end
        end
    end

`ifdef PS2_AUTOFIRE_EN
    logic af_phase;

    ps2_autofire_gen #(
        .AF_PERIOD(AF_PERIOD)
    ) u_autofire (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .phase   (af_phase)
    );

    assign held_eff = key_held & (~af_mask | {NUM_BTN{af_phase}});
`else
    logic unused_af;

    assign unused_af = ^{af_mask, AF_PERIOD[0]};
    assign held_eff  = key_held;
`endif

    assign btn_out = held_eff | joy_in;

endmodule
